// File: rtl/regfile_pkg.sv
// Shared widths, write-back payload type and round-robin helper for the regfile write-back path.
package regfile_pkg;

  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned ADDRESS_WIDTH = 5;

  // One write-back request: destination register and the value to write.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } wb_req_t;

  // Next index in a ring of n entries, wrapping from n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  int unsigned scan;

  // Walk the ring starting at ptr and stop at the first requester found.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    scan  = 32'(ptr_i);
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_c && req_i[scan]) begin
        any_c = 1'b1;
        idx_c = IW'(scan);
      end
      scan = rr_next(scan, N);
    end
    if (any_c) gnt_c = N'(1) << idx_c;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between NUM_REQ write-back sources.
// Optional same-cycle read bypass of the registered write: define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
  parameter int unsigned NUM_REQ       = 3,
  localparam int unsigned GIDW         = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wb_stall,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [ADDRESS_WIDTH-1:0]         byp_ra1,
  input  logic [ADDRESS_WIDTH-1:0]         byp_ra2,
  input  logic [DATA_WIDTH-1:0]            byp_rd1_in,
  input  logic [DATA_WIDTH-1:0]            byp_rd2_in,
  output logic [DATA_WIDTH-1:0]            byp_rd1,
  output logic [DATA_WIDTH-1:0]            byp_rd2,
`endif
  output logic                             RegWrite,
  output logic [ADDRESS_WIDTH-1:0]         wa,
  output logic [DATA_WIDTH-1:0]            wd,
  output logic [GIDW-1:0]                  grant_id
);

  logic [NUM_REQ-1:0]       arb_req;
  logic [NUM_REQ-1:0]       arb_gnt;
  logic [GIDW-1:0]          arb_idx;
  logic                     arb_any;
  logic [ADDRESS_WIDTH-1:0] sel_addr;

  logic                     we_q,  we_d;
  logic [ADDRESS_WIDTH-1:0] wa_q,  wa_d;
  logic [DATA_WIDTH-1:0]    wd_q,  wd_d;
  logic [GIDW-1:0]          gid_q, gid_d;
  logic [GIDW-1:0]          ptr_q, ptr_d;

  // Stall hides every request so nothing is granted and the pointer stays put.
  assign arb_req = wb_stall ? '0 : req_valid;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (GIDW)
  ) u_rr (
    .req_i (arb_req),
    .ptr_i (ptr_q),
    .gnt_c (arb_gnt),
    .idx_c (arb_idx),
    .any_c (arb_any)
  );

  // Grant is combinational; forced low while reset is asserted.
  assign req_ready = arb_gnt & {NUM_REQ{reset_n}};

  // Load the output stage from the granted requester; x0 targets are consumed without a write.
  always_comb begin
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    sel_addr = req_addr[arb_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    if (arb_any) begin
      we_d  = (sel_addr != '0);
      wa_d  = sel_addr;
      wd_d  = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      gid_d = arb_idx;
      ptr_d = GIDW'(regfile_pkg::rr_next(32'(arb_idx), NUM_REQ));
    end
  end

  // Output stage and round-robin pointer; reset drops any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      gid_q <= '0;
      ptr_q <= '0;
    end else begin
      we_q  <= we_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
      gid_q <= gid_d;
      ptr_q <= ptr_d;
    end
  end

  assign RegWrite = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign grant_id = gid_q;

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the write being committed this cycle to matching read ports; x0 never forwards.
  assign byp_rd1 = (we_q && (wa_q == byp_ra1) && (wa_q != '0)) ? wd_q : byp_rd1_in;
  assign byp_rd2 = (we_q && (wa_q == byp_ra2) && (wa_q != '0)) ? wd_q : byp_rd2_in;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default 3 requesters, 64-bit data).
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wb_stall;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic             RegWrite;
  logic [AW-1:0]    wa;
  logic [DW-1:0]    wd;
  logic [1:0]       grant_id;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0]    byp_ra1, byp_ra2;
  logic [DW-1:0]    byp_rd1_in, byp_rd2_in, byp_rd1, byp_rd2;
`endif

  wb_req_t rq [NR];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Pack per-requester payloads onto the flat DUT buses.
  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = rq[i].addr;
      req_data[i*DW +: DW] = rq[i].data;
    end
  end

  regfile_wb_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wb_stall   (wb_stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
`ifdef REGFILE_WB_BYPASS_EN
    .byp_ra1    (byp_ra1),
    .byp_ra2    (byp_ra2),
    .byp_rd1_in (byp_rd1_in),
    .byp_rd2_in (byp_rd2_in),
    .byp_rd1    (byp_rd1),
    .byp_rd2    (byp_rd2),
`endif
    .RegWrite   (RegWrite),
    .wa         (wa),
    .wd         (wd),
    .grant_id   (grant_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq[i].addr = a;
    rq[i].data = d;
  endtask

  initial begin
    reset_n   = 1'b0;
    wb_stall  = 1'b0;
    req_valid = '0;
    set_req(0, 5'd1, 64'h11);
    set_req(1, 5'd2, 64'h22);
    set_req(2, 5'd3, 64'h33);
`ifdef REGFILE_WB_BYPASS_EN
    byp_ra1 = '0; byp_ra2 = '0; byp_rd1_in = '0; byp_rd2_in = '0;
`endif
    tick();
    tick();

    // Reset held with all requesters valid.
    req_valid = 3'b111;
    #1;
    chk("rst_we",    64'(RegWrite),  64'd0);
    chk("rst_wa",    64'(wa),        64'd0);
    chk("rst_wd",    wd,             64'd0);
    chk("rst_gid",   64'(grant_id),  64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);

    // Release between edges; fairness over a full rotation.
    reset_n = 1'b1;
    #1;
    chk("rel_ready", 64'(req_ready), 64'b001);
    tick();
    chk("rr0_we",  64'(RegWrite),  64'd1);
    chk("rr0_wa",  64'(wa),        64'd1);
    chk("rr0_wd",  wd,             64'h11);
    chk("rr0_gid", 64'(grant_id),  64'd0);
    chk("rr0_rdy", 64'(req_ready), 64'b010);
    tick();
    chk("rr1_wa",  64'(wa),        64'd2);
    chk("rr1_gid", 64'(grant_id),  64'd1);
    chk("rr1_rdy", 64'(req_ready), 64'b100);
    tick();
    chk("rr2_wa",  64'(wa),        64'd3);
    chk("rr2_gid", 64'(grant_id),  64'd2);
    chk("rr2_rdy", 64'(req_ready), 64'b001);
    tick();
    chk("rr3_we",  64'(RegWrite),  64'd1);
    chk("rr3_wa",  64'(wa),        64'd1);
    chk("rr3_gid", 64'(grant_id),  64'd0);

    // Mid-cycle reset drops the pending write and rewinds the pointer.
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we",  64'(RegWrite),  64'd0);
    chk("mid_rst_rdy", 64'(req_ready), 64'd0);
    #1;
    reset_n = 1'b1;
    #1;
    chk("mid_rel_rdy", 64'(req_ready), 64'b001);
    req_valid = '0;
    tick();
    chk("idle_we", 64'(RegWrite), 64'd0);
    chk("idle_wa", 64'(wa),       64'd0);

    // Sparse: only requester 2.
    set_req(2, 5'd7, 64'hDEAD);
    req_valid = 3'b100;
    #1;
    chk("sp_rdy", 64'(req_ready), 64'b100);
    tick();
    req_valid = '0;
    chk("sp_we",  64'(RegWrite), 64'd1);
    chk("sp_wa",  64'(wa),       64'd7);
    chk("sp_wd",  wd,            64'hDEAD);
    chk("sp_gid", 64'(grant_id), 64'd2);
    tick();
    chk("sp_hold_we",  64'(RegWrite), 64'd0);
    chk("sp_hold_wa",  64'(wa),       64'd7);
    chk("sp_hold_gid", 64'(grant_id), 64'd2);

    // x0 destination: consumed, no write, pointer moves to 2.
    set_req(1, 5'd0, 64'h55);
    req_valid = 3'b010;
    #1;
    chk("x0_rdy", 64'(req_ready), 64'b010);
    tick();
    chk("x0_we",  64'(RegWrite), 64'd0);
    chk("x0_wa",  64'(wa),       64'd0);
    chk("x0_wd",  wd,            64'h55);
    chk("x0_gid", 64'(grant_id), 64'd1);
    req_valid = 3'b111;
    #1;
    chk("x0_ptr_rdy", 64'(req_ready), 64'b100);

    // Stall three cycles; both remaining requesters target the same register.
    set_req(0, 5'd9, 64'hA0);
    set_req(1, 5'd9, 64'hA1);
    req_valid = 3'b011;
    wb_stall  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_rdy", k), 64'(req_ready), 64'd0);
      tick();
      chk($sformatf("stall%0d_we", k), 64'(RegWrite), 64'd0);
    end
    wb_stall = 1'b0;
    #1;
    chk("unstall_rdy", 64'(req_ready), 64'b001);
    tick();
    chk("same0_we",  64'(RegWrite),  64'd1);
    chk("same0_wa",  64'(wa),        64'd9);
    chk("same0_wd",  wd,             64'hA0);
    chk("same0_gid", 64'(grant_id),  64'd0);
    chk("same0_rdy", 64'(req_ready), 64'b010);
    tick();
    chk("same1_we",  64'(RegWrite), 64'd1);
    chk("same1_wa",  64'(wa),       64'd9);
    chk("same1_wd",  wd,            64'hA1);
    chk("same1_gid", 64'(grant_id), 64'd1);
    req_valid = '0;
    tick();
    chk("drain_we", 64'(RegWrite), 64'd0);
    chk("drain_wd", wd,            64'hA1);

`ifdef REGFILE_WB_BYPASS_EN
    // Bypass of the write currently being committed.
    set_req(0, 5'd5, 64'd9);
    req_valid = 3'b001;
    tick();
    req_valid  = '0;
    byp_ra1    = 5'd5;
    byp_rd1_in = 64'd0;
    byp_ra2    = 5'd0;
    byp_rd2_in = 64'h77;
    #1;
    chk("byp_we",  64'(RegWrite), 64'd1);
    chk("byp_rd1", byp_rd1,       64'd9);
    chk("byp_rd2", byp_rd2,       64'h77);
    byp_ra1    = 5'd4;
    byp_rd1_in = 64'h44;
    #1;
    chk("byp_miss", byp_rd1, 64'h44);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
